// File: rtl/dcache_pkg.sv
// Shared definitions for the L1 data cache: FSM state encoding, address
// field widths, the cache line type and a word-merge helper.
package dcache_pkg;

  localparam int ADDR_W         = 32;
  localparam int LINE_BITS      = 256;
  localparam int WORD_W         = 32;
  localparam int WORDS_PER_LINE = LINE_BITS / WORD_W;
  localparam int OFF_W          = 5;
  localparam int WSEL_W         = 3;
  localparam int DEF_NUM_LINES  = 16;

  typedef logic [LINE_BITS-1:0] line_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITEBACK,
    ST_REFILL_REQ,
    ST_REFILL
  } state_t;

  // Replace one 32-bit word of a line, leaving the other words untouched.
  function automatic line_t mergeWord(input line_t line,
                                      input logic [WSEL_W-1:0] sel,
                                      input logic [WORD_W-1:0] word);
    line_t merged;
    merged = line;
    merged[sel*WORD_W +: WORD_W] = word;
    return merged;
  endfunction

endpackage

// File: rtl/dcache_sram.sv
// Storage for the direct-mapped data cache: per-line valid, dirty, tag and
// 256-bit data. One combinational read port, one write port that either
// installs a whole clean line or merges a single word and marks it dirty.
module dcache_sram
  import dcache_pkg::*;
#(
  parameter int NUM_LINES = DEF_NUM_LINES,
  parameter int IDX_W     = $clog2(NUM_LINES),
  parameter int TAG_W     = ADDR_W - IDX_W - OFF_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [IDX_W-1:0]  i_rdIdx,
  output logic              o_rdValid,
  output logic              o_rdDirty,
  output logic [TAG_W-1:0]  o_rdTag,
  output line_t             o_rdLine,
  input  logic              i_wrEn,
  input  logic              i_wrMerge,
  input  logic [IDX_W-1:0]  i_wrIdx,
  input  logic [TAG_W-1:0]  i_wrTag,
  input  line_t             i_wrLine,
  input  logic [WSEL_W-1:0] i_wrSel,
  input  logic [WORD_W-1:0] i_wrWord
);

  logic [NUM_LINES-1:0] r_valid;
  logic [NUM_LINES-1:0] r_dirty;
  logic [TAG_W-1:0]     r_tag  [NUM_LINES];
  line_t                r_data [NUM_LINES];

  assign o_rdValid = r_valid[i_rdIdx];
  assign o_rdDirty = r_dirty[i_rdIdx];
  assign o_rdTag   = r_tag[i_rdIdx];
  assign o_rdLine  = r_data[i_rdIdx];

  // Line status bits: cleared on reset, set by refill or by a merged store.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else if (i_wrEn) begin
      if (i_wrMerge) begin
        r_dirty[i_wrIdx] <= 1'b1;
      end else begin
        r_valid[i_wrIdx] <= 1'b1;
        r_dirty[i_wrIdx] <= 1'b0;
      end
    end
  end

  // Tag and data arrays carry no reset; the valid bits make stale contents harmless.
  always_ff @(posedge clk_i) begin
    if (i_wrEn && !rst_i) begin
      if (i_wrMerge) begin
        r_data[i_wrIdx] <= mergeWord(r_data[i_wrIdx], i_wrSel, i_wrWord);
      end else begin
        r_data[i_wrIdx] <= i_wrLine;
        r_tag[i_wrIdx]  <= i_wrTag;
      end
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate L1 data cache controller for the
// MEM stage. Hits complete combinationally without stalling; misses walk
// WRITEBACK (dirty victim) and REFILL_REQ/REFILL against the line memory.
// Optional hit/miss counters are built when DCACHE_STATS_EN is defined;
// otherwise hit_cnt_o and miss_cnt_o are tied to zero.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int NUM_LINES = DEF_NUM_LINES
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [ADDR_W-1:0]    cpu_addr_i,
  input  logic [WORD_W-1:0]    cpu_data_i,
  input  logic                 cpu_MemRead_i,
  input  logic                 cpu_MemWrite_i,
  output logic [WORD_W-1:0]    cpu_data_o,
  output logic                 cpu_stall_o,
  output logic [ADDR_W-1:0]    mem_addr_o,
  output logic [LINE_BITS-1:0] mem_data_o,
  output logic                 mem_enable_o,
  output logic                 mem_write_o,
  input  logic [LINE_BITS-1:0] mem_data_i,
  input  logic                 mem_ack_i,
  output logic [31:0]          hit_cnt_o,
  output logic [31:0]          miss_cnt_o
);

  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = ADDR_W - IDX_W - OFF_W;

  state_t           r_state;
  logic             r_memEnable;
  logic             r_memWrite;
  logic [ADDR_W-1:0] r_memAddr;
  line_t            r_memData;
  line_t            r_refillLine;

  logic              w_req;
  logic              w_isWrite;
  logic              w_isRead;
  logic [TAG_W-1:0]  w_tag;
  logic [IDX_W-1:0]  w_idx;
  logic [WSEL_W-1:0] w_sel;
  logic              w_rdValid;
  logic              w_rdDirty;
  logic [TAG_W-1:0]  w_rdTag;
  line_t             w_rdLine;
  logic              w_hit;
  logic              w_idleHit;
  logic [WORD_W-1:0] w_word;
  logic              w_wrEn;
  logic              w_wrMerge;
  logic              w_unusedByteOffset;

  // A simultaneous read and write is resolved as a write.
  assign w_req     = cpu_MemRead_i | cpu_MemWrite_i;
  assign w_isWrite = cpu_MemWrite_i;
  assign w_isRead  = cpu_MemRead_i & ~cpu_MemWrite_i;

  assign w_tag = cpu_addr_i[ADDR_W-1 -: TAG_W];
  assign w_idx = cpu_addr_i[IDX_W+OFF_W-1 : OFF_W];
  assign w_sel = cpu_addr_i[OFF_W-1 : 2];
  assign w_unusedByteOffset = ^cpu_addr_i[1:0];

  assign w_hit     = w_req & w_rdValid & (w_rdTag == w_tag);
  assign w_idleHit = (r_state == ST_IDLE) & w_hit;
  assign w_word    = w_rdLine[w_sel*WORD_W +: WORD_W];

  assign cpu_stall_o = w_req & ~w_idleHit;
  assign cpu_data_o  = (w_idleHit && w_isRead) ? w_word : '0;

  // Store hits merge in IDLE; the REFILL state installs the fetched line.
  assign w_wrEn    = (w_idleHit & w_isWrite) | (r_state == ST_REFILL);
  assign w_wrMerge = (r_state == ST_IDLE);

  assign mem_enable_o = r_memEnable;
  assign mem_write_o  = r_memWrite;
  assign mem_addr_o   = r_memAddr;
  assign mem_data_o   = r_memData;

  dcache_sram #(
    .NUM_LINES (NUM_LINES),
    .IDX_W     (IDX_W),
    .TAG_W     (TAG_W)
  ) u_sram (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .i_rdIdx   (w_idx),
    .o_rdValid (w_rdValid),
    .o_rdDirty (w_rdDirty),
    .o_rdTag   (w_rdTag),
    .o_rdLine  (w_rdLine),
    .i_wrEn    (w_wrEn),
    .i_wrMerge (w_wrMerge),
    .i_wrIdx   (w_idx),
    .i_wrTag   (w_tag),
    .i_wrLine  (r_refillLine),
    .i_wrSel   (w_sel),
    .i_wrWord  (cpu_data_i)
  );

  // Miss FSM with registered memory-side request; outputs stay put until ack.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= ST_IDLE;
      r_memEnable  <= 1'b0;
      r_memWrite   <= 1'b0;
      r_memAddr    <= '0;
      r_memData    <= '0;
      r_refillLine <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_req && !w_hit) begin
            r_memEnable <= 1'b1;
            if (w_rdValid && w_rdDirty) begin
              r_state    <= ST_WRITEBACK;
              r_memWrite <= 1'b1;
              r_memAddr  <= {w_rdTag, w_idx, {OFF_W{1'b0}}};
              r_memData  <= w_rdLine;
            end else begin
              r_state    <= ST_REFILL_REQ;
              r_memWrite <= 1'b0;
              r_memAddr  <= {w_tag, w_idx, {OFF_W{1'b0}}};
            end
          end
        end
        ST_WRITEBACK: begin
          if (mem_ack_i) begin
            r_state    <= ST_REFILL_REQ;
            r_memWrite <= 1'b0;
            r_memAddr  <= {w_tag, w_idx, {OFF_W{1'b0}}};
          end
        end
        ST_REFILL_REQ: begin
          if (mem_ack_i) begin
            r_state      <= ST_REFILL;
            r_memEnable  <= 1'b0;
            r_refillLine <= mem_data_i;
          end
        end
        ST_REFILL: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef DCACHE_STATS_EN
  logic [31:0] r_hitCnt;
  logic [31:0] r_missCnt;
  logic        r_afterRefill;

  // The hit that retires a refilled request is not a fresh hit, so it is skipped.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_hitCnt      <= '0;
      r_missCnt     <= '0;
      r_afterRefill <= 1'b0;
    end else begin
      r_afterRefill <= (r_state == ST_REFILL);
      if (w_idleHit && !r_afterRefill) begin
        r_hitCnt <= r_hitCnt + 32'd1;
      end
      if ((r_state == ST_IDLE) && w_req && !w_hit) begin
        r_missCnt <= r_missCnt + 32'd1;
      end
    end
  end

  assign hit_cnt_o  = r_hitCnt;
  assign miss_cnt_o = r_missCnt;
`else
  assign hit_cnt_o  = '0;
  assign miss_cnt_o = '0;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: a memory responder with fixed ack
// latency plus a line-level cache model predicting stall length, load data,
// write-backs and (when DCACHE_STATS_EN is defined) the hit/miss counters.
module tb_dcache_ctrl;

  localparam int LAT = 10;

  logic         clk = 1'b0;
  logic         rst_i = 1'b1;
  logic [31:0]  cpu_addr_i = '0;
  logic [31:0]  cpu_data_i = '0;
  logic         cpu_MemRead_i = 1'b0;
  logic         cpu_MemWrite_i = 1'b0;
  logic [31:0]  cpu_data_o;
  logic         cpu_stall_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic         mem_enable_o;
  logic         mem_write_o;
  logic [255:0] mem_data_i = '0;
  logic         mem_ack_i = 1'b0;
  logic [31:0]  hit_cnt_o;
  logic [31:0]  miss_cnt_o;

  int checks = 0;
  int failures = 0;

  // Backing store as seen by the memory device, and the model's coherent view.
  logic [31:0] devMem   [int unsigned];
  logic [31:0] modelMem [int unsigned];

  // Model cache contents, one entry per index.
  bit          mValid [16];
  bit          mDirty [16];
  logic [22:0] mTag   [16];
  logic [31:0] mLine  [16][8];
  int          mHits = 0;
  int          mMisses = 0;

  int          expStall;
  logic [31:0] expData;
  bit          expWb;
  logic [31:0] expWbAddr;
  logic [31:0] expWbWord0;
  int          lastStall;

  int          rCnt = 0;
  bit          rPend = 1'b0;
  logic [31:0] rAddr = '0;
  logic        rWrite = 1'b0;
  int          wbCount = 0;
  logic [31:0] wbAddr = '0;
  logic [31:0] wbWord0 = '0;
  bit          injectAck = 1'b0;

  always #5 clk = ~clk;

  dcache_ctrl dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .cpu_addr_i     (cpu_addr_i),
    .cpu_data_i     (cpu_data_i),
    .cpu_MemRead_i  (cpu_MemRead_i),
    .cpu_MemWrite_i (cpu_MemWrite_i),
    .cpu_data_o     (cpu_data_o),
    .cpu_stall_o    (cpu_stall_o),
    .mem_addr_o     (mem_addr_o),
    .mem_data_o     (mem_data_o),
    .mem_enable_o   (mem_enable_o),
    .mem_write_o    (mem_write_o),
    .mem_data_i     (mem_data_i),
    .mem_ack_i      (mem_ack_i),
    .hit_cnt_o      (hit_cnt_o),
    .miss_cnt_o     (miss_cnt_o)
  );

  function automatic logic [31:0] initWord(input logic [31:0] a);
    if (a == 32'h0000_0040) return 32'hDEADBEEF;
    return {16'hC0DE, a[15:0]};
  endfunction

  function automatic logic [31:0] devRead(input logic [31:0] a);
    if (devMem.exists(a >> 2)) return devMem[a >> 2];
    return initWord(a);
  endfunction

  function automatic logic [31:0] modelRead(input logic [31:0] a);
    if (modelMem.exists(a >> 2)) return modelMem[a >> 2];
    return initWord(a);
  endfunction

  function automatic logic [31:0] expHitCnt();
`ifdef DCACHE_STATS_EN
    return mHits;
`else
    return 32'd0;
`endif
  endfunction

  function automatic logic [31:0] expMissCnt();
`ifdef DCACHE_STATS_EN
    return mMisses;
`else
    return 32'd0;
`endif
  endfunction

  // Memory device: acks on the LAT-th cycle a request is held, commits writes, serves reads.
  always @(negedge clk) begin
    mem_ack_i = 1'b0;
    if (mem_enable_o === 1'b1) begin
      if (rPend && mem_addr_o == rAddr && mem_write_o == rWrite) begin
        rCnt++;
      end else begin
        rCnt   = 1;
        rAddr  = mem_addr_o;
        rWrite = mem_write_o;
      end
      rPend = 1'b1;
      if (rCnt == LAT) begin
        mem_ack_i = 1'b1;
        rPend     = 1'b0;
        if (mem_write_o) begin
          for (int w = 0; w < 8; w++) devMem[(mem_addr_o >> 2) + w] = mem_data_o[w*32 +: 32];
          wbCount++;
          wbAddr  = mem_addr_o;
          wbWord0 = mem_data_o[31:0];
        end else begin
          for (int w = 0; w < 8; w++) mem_data_i[w*32 +: 32] = devRead(mem_addr_o + w*4);
        end
      end
    end else begin
      rPend = 1'b0;
    end
    if (injectAck) mem_ack_i = 1'b1;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, actual, required);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 16; i++) begin
      mValid[i] = 1'b0;
      mDirty[i] = 1'b0;
    end
    mHits   = 0;
    mMisses = 0;
  endtask

  task automatic modelAccess(input logic wr, input logic [31:0] addr, input logic [31:0] data);
    int          idx;
    int          w;
    logic [22:0] tag;
    idx   = int'(addr[8:5]);
    w     = int'(addr[4:2]);
    tag   = addr[31:9];
    expWb = 1'b0;
    expData = '0;
    if (mValid[idx] && mTag[idx] == tag) begin
      expStall = 0;
      mHits++;
    end else begin
      mMisses++;
      if (mValid[idx] && mDirty[idx]) begin
        expWb      = 1'b1;
        expWbAddr  = {mTag[idx], idx[3:0], 5'b0};
        expWbWord0 = mLine[idx][0];
        for (int k = 0; k < 8; k++) modelMem[(expWbAddr >> 2) + k] = mLine[idx][k];
        expStall = 2*LAT + 2;
      end else begin
        expStall = LAT + 2;
      end
      for (int k = 0; k < 8; k++) mLine[idx][k] = modelRead({tag, idx[3:0], 5'b0} + k*4);
      mValid[idx] = 1'b1;
      mDirty[idx] = 1'b0;
      mTag[idx]   = tag;
    end
    if (wr) begin
      mLine[idx][w] = data;
      mDirty[idx]   = 1'b1;
    end else begin
      expData = mLine[idx][w];
    end
  endtask

  // Drive one held request until the stall drops, checking every cycle along the way.
  task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] data);
    int stall;
    int wbBefore;
    modelAccess(wr, addr, data);
    wbBefore       = wbCount;
    cpu_MemRead_i  = rd;
    cpu_MemWrite_i = wr;
    cpu_addr_i     = addr;
    cpu_data_i     = data;
    #1;
    stall = 0;
    while (cpu_stall_o === 1'b1 && stall < 200) begin
      checkOutput("dataZeroWhileStalled", cpu_data_o, 32'd0);
      if (!expWb) checkOutput("noWriteOnCleanMiss", {31'd0, mem_write_o}, 32'd0);
      stall++;
      @(negedge clk);
      #1;
    end
    if (stall >= 200) begin
      failures++;
      $display("[TB] FAIL stallTimeout addr=0x%08h actual=%0d cycles required=%0d", addr, stall, expStall);
    end
    lastStall = stall;
    checkOutput("stallCycles", stall, expStall);
    checkOutput("loadData", cpu_data_o, expData);
    checkOutput("writebackCount", wbCount - wbBefore, {31'd0, expWb});
    if (expWb) begin
      checkOutput("writebackAddr", wbAddr, expWbAddr);
      checkOutput("writebackWord0", wbWord0, expWbWord0);
    end
    @(negedge clk);
    cpu_MemRead_i  = 1'b0;
    cpu_MemWrite_i = 1'b0;
    #1;
    checkOutput("hitCount", hit_cnt_o, expHitCnt());
    checkOutput("missCount", miss_cnt_o, expMissCnt());
  endtask

  // Absolute time limit so a wedged design still reaches a verdict.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int waitCycles;
    modelReset();
    repeat (3) @(negedge clk);
    #1;
    checkOutput("resetStall", {31'd0, cpu_stall_o}, 32'd0);
    checkOutput("resetData", cpu_data_o, 32'd0);
    checkOutput("resetMemEnable", {31'd0, mem_enable_o}, 32'd0);
    checkOutput("resetMemWrite", {31'd0, mem_write_o}, 32'd0);
    checkOutput("resetMemAddr", mem_addr_o, 32'd0);
    checkOutput("resetHitCnt", hit_cnt_o, 32'd0);
    checkOutput("resetMissCnt", miss_cnt_o, 32'd0);
    @(negedge clk);
    rst_i = 1'b0;

    // Clean load miss, then a hit on the neighbouring word.
    applyStimulus(1'b1, 1'b0, 32'h0000_0040, 32'd0);
    checkOutput("firstMissStall", lastStall, 32'd12);
    checkOutput("firstMissLoad", expData, 32'hDEADBEEF);
`ifdef DCACHE_STATS_EN
    checkOutput("firstMissCount", miss_cnt_o, 32'd1);
`endif
    applyStimulus(1'b1, 1'b0, 32'h0000_0044, 32'd0);
    checkOutput("hitNoStall", lastStall, 32'd0);
    checkOutput("hitWord1", expData, 32'hC0DE0044);

    // Dirty the line, then evict it through a conflicting tag.
    applyStimulus(1'b0, 1'b1, 32'h0000_0040, 32'h1234_5678);
    applyStimulus(1'b1, 1'b0, 32'h0000_0240, 32'd0);
    checkOutput("dirtyMissStall", lastStall, 32'd22);
    checkOutput("victimAddr", wbAddr, 32'h0000_0040);
    checkOutput("victimWord0", wbWord0, 32'h1234_5678);

    // Store miss allocates, then the stored word reads back.
    applyStimulus(1'b0, 1'b1, 32'h0000_0460, 32'hCAFE_F00D);
    applyStimulus(1'b1, 1'b0, 32'h0000_0460, 32'd0);
    checkOutput("storeMissReadback", expData, 32'hCAFE_F00D);
    applyStimulus(1'b1, 1'b0, 32'h0000_0044, 32'd0);

    // Read and write together on a hit behave as a store that dirties the line.
    applyStimulus(1'b1, 1'b1, 32'h0000_0464, 32'hBEEF_0001);
    applyStimulus(1'b1, 1'b0, 32'h0000_0464, 32'd0);
    applyStimulus(1'b1, 1'b0, 32'h0000_0660, 32'd0);
    checkOutput("bothHighDirtyEvict", lastStall, 32'd22);
    checkOutput("bothHighVictimAddr", wbAddr, 32'h0000_0460);

    // Abandon a refill with reset, then show a stray ack changes nothing.
    cpu_MemRead_i = 1'b1;
    cpu_addr_i    = 32'h0000_0840;
    waitCycles    = 0;
    while (mem_enable_o !== 1'b1 && waitCycles < 20) begin
      @(negedge clk);
      #1;
      waitCycles++;
    end
    checkOutput("abortRequestSeen", {31'd0, mem_enable_o}, 32'd1);
    repeat (3) @(negedge clk);
    rst_i         = 1'b1;
    cpu_MemRead_i = 1'b0;
    @(negedge clk);
    rst_i = 1'b0;
    modelReset();
    #1;
    checkOutput("abortMemEnable", {31'd0, mem_enable_o}, 32'd0);
    checkOutput("abortStall", {31'd0, cpu_stall_o}, 32'd0);
    checkOutput("abortHitCnt", hit_cnt_o, 32'd0);
    checkOutput("abortMissCnt", miss_cnt_o, 32'd0);
    injectAck = 1'b1;
    @(negedge clk);
    #1;
    injectAck = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("lateAckMemEnable", {31'd0, mem_enable_o}, 32'd0);
    checkOutput("lateAckStall", {31'd0, cpu_stall_o}, 32'd0);
    applyStimulus(1'b1, 1'b0, 32'h0000_0040, 32'd0);
    checkOutput("afterResetMissStall", lastStall, 32'd12);
    checkOutput("afterResetLoad", expData, 32'h1234_5678);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
